nibble_serial_adder_ctrl: RTL and testbench

- Sequencer that performs a WIDTH-bit (default 16-bit) add or subtract over successive cycles, using one external 4-bit adder slice of the team's adder4bit type.
- Feeds one nibble per cycle, least-significant nibble first, and carries between nibbles in an internal register.
- Produces the result and the C/Z/N/V flags.
- Sits between the processor's ALU issue logic and the shared 4-bit adder, with valid/ready handshakes on both sides.

---
 rtl/nibble_serial_adder_ctrl.sv | 108 ++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial W-bit add/subtract through one shared 4-bit adder slice, least-significant nibble first.
// Result valid NIBBLES cycles after accept; result and flags held in DONE until out_ready.
module nibble_serial_adder_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] op_a,
   input  logic [4*NIBBLES-1:0] op_b,
   input  logic                 op_sub,
   input  logic                 op_cin,
   output logic [3:0]           add_a,
   output logic [3:0]           add_b,
   output logic                 add_cin,
   input  logic [3:0]           add_s,
   input  logic                 add_cout,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] result,
   output logic                 flag_c,
   output logic                 flag_z,
   output logic                 flag_n,
   output logic                 flag_v
);

   localparam int W  = 4*NIBBLES;
   localparam int KW = $clog2(NIBBLES);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   logic [KW-1:0]   k;
   logic [KW+1:0]   base;
   logic            carry;
   logic            sub_q;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [W-1:0]    res_nxt;
   logic            last;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign base      = {k, 2'b00};
   assign last      = (k == KW'(NIBBLES-1));

   // res_nxt is the result register with the current nibble merged in, so the
   // zero flag can be registered on the final nibble edge.
   always_comb begin
      add_a   = 4'h0;
      add_b   = 4'h0;
      add_cin = 1'b0;
      res_nxt = result;
      if (state == RUN) begin
         add_a   = a_q[base +: 4];
         add_b   = sub_q ? ~b_q[base +: 4] : b_q[base +: 4];
         add_cin = carry;
         res_nxt[base +: 4] = add_s;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         k      <= '0;
         carry  <= 1'b0;
         sub_q  <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         result <= '0;
         flag_c <= 1'b0;
         flag_z <= 1'b0;
         flag_n <= 1'b0;
         flag_v <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= op_a;
                  b_q   <= op_b;
                  sub_q <= op_sub;
                  carry <= op_sub | op_cin;
                  k     <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               result <= res_nxt;
               carry  <= add_cout;
               k      <= k + 1'b1;
               if (last) begin
                  flag_c <= add_cout;
                  flag_v <= (add_a[3] == add_b[3]) && (add_s[3] != add_a[3]);
                  flag_n <= add_s[3];
                  flag_z <= (res_nxt == '0);
                  state  <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: behavioural adder slice plus a result scoreboard.
module tb_nibble_serial_adder_ctrl;
   localparam int NIBBLES = 4;
   localparam int W = 4*NIBBLES;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  op_a = '0;
   logic [W-1:0]  op_b = '0;
   logic          op_sub = 1'b0;
   logic          op_cin = 1'b0;
   logic [3:0]    add_a, add_b, add_s;
   logic          add_cin, add_cout;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  result;
   logic          flag_c, flag_z, flag_n, flag_v;

   int            n_tests = 0;
   int            n_fail = 0;
   int            cyc = 0;
   logic [W+3:0]  exp_q[$];
   int            acc_cyc[$];

   nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .op_cin(op_cin),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_s(add_s), .add_cout(add_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result),
      .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
   );

   always #5 clk = ~clk;

   assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: {result, C, Z, N, V} from whole-word arithmetic.
   function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub, input logic cin);
      longint sa, sb, sr, maxs, mins;
      logic [W:0] ur;
      logic c, v;
      maxs = (longint'(1) <<< (W-1)) - 1;
      mins = -(longint'(1) <<< (W-1));
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sub) begin
         sr = sa - sb;
         ur = {1'b0, a} - {1'b0, b};
         c  = (a >= b);
      end else begin
         sr = sa + sb + longint'(cin);
         ur = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
         c  = ur[W];
      end
      v = (sr > maxs) || (sr < mins);
      return {ur[W-1:0], c, (ur[W-1:0] == '0), ur[W-1], v};
   endfunction

   always @(negedge clk) begin : monitor
      logic [W+3:0] e;
      if (rst_n && in_valid && in_ready) begin
         exp_q.push_back(model(op_a, op_b, op_sub, op_cin));
         acc_cyc.push_back(cyc);
      end
      if (rst_n && out_valid && out_ready) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_underflow: got result %h with no pending request", result);
         end else begin
            e = exp_q.pop_front();
            if ({result, flag_c, flag_z, flag_n, flag_v} !== e) begin
               n_fail++;
               $display("FAIL result_flags: got %h C%b Z%b N%b V%b, required %h C%b Z%b N%b V%b",
                        result, flag_c, flag_z, flag_n, flag_v,
                        e[W+3:4], e[3], e[2], e[1], e[0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a request and return one step after the accepting edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin);
      bit got;
      got = 1'b0;
      op_a = a; op_b = b; op_sub = sub; op_cin = cin;
      in_valid = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = in_ready;
         tick();
      end
      in_valid = 1'b0;
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL accept_timeout: in_ready=%b, required 1", in_ready);
      end
   endtask

   // Ends at the negedge where out_valid is first seen high.
   task automatic wait_valid();
      int i;
      i = 0;
      @(negedge clk);
      while (!out_valid && i < 30) begin
         tick();
         @(negedge clk);
         i++;
      end
      n_tests++;
      if (!out_valid) begin
         n_fail++;
         $display("FAIL done_timeout: out_valid=%b, required 1", out_valid);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
      n_tests++;
      if ({result, flag_c, flag_z, flag_n, flag_v} !== '0) begin
         n_fail++;
         $display("FAIL reset_result_flags: got %h %b%b%b%b, required all 0", result, flag_c, flag_z, flag_n, flag_v);
      end
      n_tests++;
      if ({add_a, add_b, add_cin} !== 9'h0) begin
         n_fail++;
         $display("FAIL reset_adder_ports: got a=%h b=%h cin=%b, required 0", add_a, add_b, add_cin);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_nibble_sequence();
      logic [W-1:0] ta [4];
      logic [W-1:0] tbv [4];
      logic         ts [4];
      logic         tc [4];
      logic [W-1:0] beff;
      logic         c;
      logic [4:0]   nsum;
      ta  = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0003};
      tbv = '{16'h0FCD, 16'h0001, 16'h0001, 16'h0005};
      ts  = '{1'b0, 1'b0, 1'b1, 1'b1};
      tc  = '{1'b0, 1'b0, 1'b0, 1'b0};
      out_ready = 1'b1;
      for (int t = 0; t < 4; t++) begin
         issue(ta[t], tbv[t], ts[t], tc[t]);
         beff = ts[t] ? ~tbv[t] : tbv[t];
         c = ts[t] | tc[t];
         for (int k = 0; k < NIBBLES; k++) begin
            @(negedge clk);
            n_tests++;
            if ({add_a, add_b, add_cin} !== {ta[t][4*k +: 4], beff[4*k +: 4], c}) begin
               n_fail++;
               $display("FAIL adder_ports case%0d nib%0d: got a=%h b=%h cin=%b, required a=%h b=%h cin=%b",
                        t, k, add_a, add_b, add_cin, ta[t][4*k +: 4], beff[4*k +: 4], c);
            end
            n_tests++;
            if ({out_valid, in_ready} !== 2'b00) begin
               n_fail++;
               $display("FAIL run_handshake case%0d nib%0d: got out_valid=%b in_ready=%b, required 0 0",
                        t, k, out_valid, in_ready);
            end
            nsum = {1'b0, ta[t][4*k +: 4]} + {1'b0, beff[4*k +: 4]} + {4'b0, c};
            c = nsum[4];
            tick();
         end
         @(negedge clk);
         n_tests++;
         if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL latency case%0d: out_valid=%b after E0+%0d, required 1", t, out_valid, NIBBLES);
         end
         tick();
      end
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      issue(16'h7FFF, 16'h0000, 1'b0, 1'b1);
      wait_valid();
      tick();
      op_a = 16'h5555; op_b = 16'h5555; op_sub = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_tests++;
         if ({out_valid, in_ready, result, flag_c, flag_z, flag_n, flag_v} !== {2'b10, 16'h8000, 4'b0011}) begin
            n_fail++;
            $display("FAIL stall_hold cyc%0d: got ov=%b ir=%b %h %b%b%b%b, required ov=1 ir=0 8000 0011",
                     i, out_valid, in_ready, result, flag_c, flag_z, flag_n, flag_v);
         end
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      tick();
      @(negedge clk);
      n_tests++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL stall_release: got in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
      end
      tick();
   endtask

   task automatic test_reset_mid_run();
      out_ready = 1'b1;
      issue(16'h1111, 16'h2222, 1'b0, 1'b0);
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      @(negedge clk);
      n_tests++;
      if ({in_ready, out_valid, result, flag_c, flag_z, flag_n, flag_v, add_a, add_b, add_cin} !== {2'b10, 29'h0}) begin
         n_fail++;
         $display("FAIL abort_state: got ir=%b ov=%b res=%h flags=%b%b%b%b a=%h b=%h cin=%b, required ir=1 rest 0",
                  in_ready, out_valid, result, flag_c, flag_z, flag_n, flag_v, add_a, add_b, add_cin);
      end
      tick();
      issue(16'h0001, 16'h0001, 1'b0, 1'b0);
      wait_valid();
      n_tests++;
      if (result !== 16'h0002) begin
         n_fail++;
         $display("FAIL after_abort: got %h, required 0002", result);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int cnt;
      cnt = 0;
      out_ready = 1'b1;
      acc_cyc.delete();
      op_a = 16'hA5A5; op_b = 16'h1111; op_sub = 1'b0; op_cin = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 60 && cnt < 4; i++) begin
         @(negedge clk);
         if (in_ready) cnt++;
         tick();
         if (in_ready == 1'b0 && cnt > 0) begin
            op_a = op_a + 16'h3C71;
            op_b = op_b ^ 16'h9E37;
            op_sub = ~op_sub;
         end
      end
      in_valid = 1'b0;
      n_tests++;
      if (acc_cyc.size() != 4) begin
         n_fail++;
         $display("FAIL b2b_accepts: got %0d accepts, required 4", acc_cyc.size());
      end else begin
         for (int j = 1; j < 4; j++) begin
            n_tests++;
            if (acc_cyc[j] - acc_cyc[j-1] != NIBBLES + 2) begin
               n_fail++;
               $display("FAIL b2b_spacing %0d: got %0d cycles, required %0d", j, acc_cyc[j] - acc_cyc[j-1], NIBBLES + 2);
            end
         end
      end
      wait_valid();
      tick();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_nibble_sequence();
      test_stall();
      test_reset_mid_run();
      test_back_to_back();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
